// File: rtl/square_wave_period_meter_if.sv
// Signal-under-test input and measurement results of square_wave_period_meter.
// master drives the input and observes the results; slave is the meter side.
interface square_wave_period_meter_if #(
    parameter int COUNT_WIDTH = 24
);
    logic signed [15:0]     in;
    logic [COUNT_WIDTH-1:0] cycles_high;
    logic [COUNT_WIDTH-1:0] cycles_low;
    logic [COUNT_WIDTH:0]   period;
    logic                   valid;
    logic [COUNT_WIDTH:0]   avg_period;
    logic                   avg_valid;
    logic                   stalled;

    modport master (
        output in,
        input  cycles_high, cycles_low, period, valid, avg_period, avg_valid, stalled
    );

    modport slave (
        input  in,
        output cycles_high, cycles_low, period, valid, avg_period, avg_valid, stalled
    );
endinterface

// File: rtl/square_wave_period_meter.sv
// Measures high time, low time and period (in clk cycles) of a fixed-point square wave
// through a hysteresis comparator, with stall detection and a block-averaged period.
module square_wave_period_meter #(
    parameter int  SIGNAL_FRACTION_WIDTH = 14,
    parameter real VCC                   = 12.0,
    parameter real V_TH_HIGH             = 3.33,
    parameter real V_TH_LOW              = 1.67,
    parameter int  COUNT_WIDTH           = 24,
    parameter int  TIMEOUT_CYCLES        = 2000000,
    parameter int  AVG_LOG2              = 2
) (
    input  logic                     clk,
    input  logic                     I_RST,
    square_wave_period_meter_if.slave bus
);
    localparam int TH_HIGH_I = $rtoi(V_TH_HIGH * real'(1 << SIGNAL_FRACTION_WIDTH) / VCC);
    localparam int TH_LOW_I  = $rtoi(V_TH_LOW  * real'(1 << SIGNAL_FRACTION_WIDTH) / VCC);
    localparam logic signed [15:0] TH_HIGH = 16'(TH_HIGH_I);
    localparam logic signed [15:0] TH_LOW  = 16'(TH_LOW_I);

    localparam int PW    = COUNT_WIDTH + 1;
    localparam int ACC_W = PW + AVG_LOG2;
    localparam int BLK_W = AVG_LOG2 + 1;
    localparam logic [BLK_W-1:0]       BLK_LAST = BLK_W'((1 << AVG_LOG2) - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT  = COUNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {SYNC, ARM, MEAS_HIGH, MEAS_LOW} state_t;

    state_t                 state, state_next;
    logic                   level, level_next;
    logic                   at_high, at_low, rise, fall;
    logic [COUNT_WIDTH-1:0] cnt, hi_lat;
    logic [ACC_W-1:0]       acc, acc_sum;
    logic [BLK_W-1:0]       blk;
    logic [PW-1:0]          period_new;
    logic                   start, latch_high, done, timeout;

    assign at_high    = bus.in >= TH_HIGH;
    assign at_low     = bus.in <= TH_LOW;
    assign rise       = !level && level_next;
    assign fall       = level && !level_next;
    assign period_new = {1'b0, hi_lat} + {1'b0, cnt};
    assign acc_sum    = acc + ACC_W'(period_new);

    always_comb begin
        level_next = level;
        if (at_high)
            level_next = 1'b1;
        else if (at_low)
            level_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (I_RST)
            state <= SYNC;
        else
            state <= state_next;
    end

    // A transition on the timeout edge wins, so a phase of exactly TIMEOUT_CYCLES is still measured.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        latch_high = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            SYNC: begin
                if (!level && !at_high)
                    state_next = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_next = MEAS_HIGH;
                    start      = 1'b1;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    state_next = MEAS_LOW;
                    latch_high = 1'b1;
                end else if (cnt == TIMEOUT) begin
                    state_next = SYNC;
                    timeout    = 1'b1;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    state_next = MEAS_HIGH;
                    done       = 1'b1;
                end else if (cnt == TIMEOUT) begin
                    state_next = SYNC;
                    timeout    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            level           <= 1'b0;
            cnt             <= '0;
            hi_lat          <= '0;
            acc             <= '0;
            blk             <= '0;
            bus.cycles_high <= '0;
            bus.cycles_low  <= '0;
            bus.period      <= '0;
            bus.valid       <= 1'b0;
            bus.avg_period  <= '0;
            bus.avg_valid   <= 1'b0;
            bus.stalled     <= 1'b0;
        end else begin
            level         <= level_next;
            bus.valid     <= 1'b0;
            bus.avg_valid <= 1'b0;

            if (start || latch_high || done)
                cnt <= COUNT_WIDTH'(1);
            else if (timeout)
                cnt <= '0;
            else if (state == MEAS_HIGH || state == MEAS_LOW)
                cnt <= cnt + 1'b1;

            if (latch_high)
                hi_lat <= cnt;

            if (done) begin
                bus.cycles_high <= hi_lat;
                bus.cycles_low  <= cnt;
                bus.period      <= period_new;
                bus.valid       <= 1'b1;
                bus.stalled     <= 1'b0;
                if (blk == BLK_LAST) begin
                    bus.avg_period <= acc_sum[AVG_LOG2 +: PW];
                    bus.avg_valid  <= 1'b1;
                    acc            <= '0;
                    blk            <= '0;
                end else begin
                    acc <= acc_sum;
                    blk <= blk + 1'b1;
                end
            end

            if (timeout) begin
                bus.stalled <= 1'b1;
                acc         <= '0;
                blk         <= '0;
            end
        end
    end
endmodule

// File: tb/tb_square_wave_period_meter.sv
// Self-checking bench for square_wave_period_meter: waveforms are built phase by phase,
// so expected lengths, periods and block averages follow directly from the stimulus.
module tb_square_wave_period_meter;
    localparam int CW = 24;
    localparam int PW = CW + 1;
    localparam int TO = 1000;
    localparam int AL = 2;
    // floor(3.33 / 12 * 2^14) and floor(1.67 / 12 * 2^14)
    localparam int TH_HI = 4546;
    localparam int TH_LO = 2280;
    localparam int V5 = 'h1C00;

    logic clk = 1'b0;
    logic I_RST;
    always #5 clk = ~clk;

    square_wave_period_meter_if #(.COUNT_WIDTH(CW)) bus ();

    square_wave_period_meter #(
        .COUNT_WIDTH(CW),
        .TIMEOUT_CYCLES(TO),
        .AVG_LOG2(AL)
    ) dut (
        .clk(clk),
        .I_RST(I_RST),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    logic last_valid, last_avg;
    int blk_q[$];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one input sample and observe the outputs just after the edge that samples it.
    task automatic step(input int v);
        @(negedge clk);
        bus.in = 16'(v);
        @(posedge clk);
        #1;
        last_valid = bus.valid;
        last_avg   = bus.avg_valid;
        if (bus.valid === 1'b1) n_valid++;
    endtask

    function automatic int hi_first();
        if ($urandom_range(3, 0) == 0) return TH_HI;
        return int'($urandom_range(32767, TH_HI));
    endfunction

    function automatic int hi_rest();
        return int'($urandom_range(32767, TH_LO + 1));
    endfunction

    function automatic int lo_first();
        if ($urandom_range(3, 0) == 0) return TH_LO;
        return int'($urandom_range(TH_LO + 32768, 0)) - 32768;
    endfunction

    function automatic int lo_rest();
        return int'($urandom_range(TH_HI - 1 + 32768, 0)) - 32768;
    endfunction

    task automatic rise(input bit plain);
        step(plain ? V5 : hi_first());
    endtask

    task automatic high_tail(input int n, input bit plain);
        for (int i = 0; i < n; i++) step(plain ? V5 : hi_rest());
    endtask

    task automatic low_phase(input int n, input bit plain);
        for (int i = 0; i < n; i++)
            step(plain ? 0 : (i == 0 ? lo_first() : lo_rest()));
    endtask

    task automatic do_reset(input int v);
        @(negedge clk);
        I_RST  = 1'b1;
        bus.in = 16'(v);
        @(posedge clk);
        #1;
        @(negedge clk);
        I_RST = 1'b0;
        blk_q.delete();
    endtask

    task automatic test_reset();
        I_RST  = 1'b1;
        bus.in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.cycles_high !== '0) begin n_err++; $display("FAIL reset_hi: got %0d expected 0", bus.cycles_high); end
        n_vec++; if (bus.cycles_low !== '0) begin n_err++; $display("FAIL reset_lo: got %0d expected 0", bus.cycles_low); end
        n_vec++; if (bus.period !== '0) begin n_err++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
        n_vec++; if (bus.avg_period !== '0) begin n_err++; $display("FAIL reset_avg: got %0d expected 0", bus.avg_period); end
        n_vec++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_vec++; if (bus.avg_valid !== 1'b0) begin n_err++; $display("FAIL reset_avg_valid: got %b expected 0", bus.avg_valid); end
        n_vec++; if (bus.stalled !== 1'b0) begin n_err++; $display("FAIL reset_stalled: got %b expected 0", bus.stalled); end
        @(negedge clk);
        I_RST = 1'b0;
    endtask

    task automatic test_basic_period();
        int n0;
        do_reset(0);
        low_phase(3, 1);
        n0 = n_valid;
        rise(1);
        n_vec++; if (last_valid !== 1'b0) begin n_err++; $display("FAIL basic_first_rise: got valid %b expected 0", last_valid); end
        for (int k = 0; k < 3; k++) begin
            high_tail(99, 1);
            low_phase(50, 1);
            rise(1);
            n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b expected 1", k, last_valid); end
            n_vec++; if (bus.cycles_high !== CW'(100)) begin n_err++; $display("FAIL basic_hi[%0d]: got %0d expected 100", k, bus.cycles_high); end
            n_vec++; if (bus.cycles_low !== CW'(50)) begin n_err++; $display("FAIL basic_lo[%0d]: got %0d expected 50", k, bus.cycles_low); end
            n_vec++; if (bus.period !== PW'(150)) begin n_err++; $display("FAIL basic_period[%0d]: got %0d expected 150", k, bus.period); end
            n_vec++; if (n_valid !== n0 + k + 1) begin n_err++; $display("FAIL basic_count[%0d]: got %0d expected %0d", k, n_valid - n0, k + 1); end
        end
    endtask

    task automatic test_averaging();
        do_reset(0);
        low_phase(3, 1);
        rise(1);
        for (int k = 0; k < 4; k++) begin
            high_tail(99, 1);
            low_phase(50 + 2 * k, 1);
            rise(1);
            n_vec++; if (bus.period !== PW'(150 + 2 * k)) begin n_err++; $display("FAIL avg_period_in[%0d]: got %0d expected %0d", k, bus.period, 150 + 2 * k); end
            n_vec++; if (last_avg !== (k == 3)) begin n_err++; $display("FAIL avg_valid[%0d]: got %b expected %b", k, last_avg, k == 3); end
        end
        n_vec++; if (bus.avg_period !== PW'(153)) begin n_err++; $display("FAIL avg_value: got %0d expected 153", bus.avg_period); end
    endtask

    task automatic test_hysteresis();
        int hi_seq[] = '{3000, 2413, 4413, 2413, 4413, 2281, V5, V5, V5, V5};
        int lo_seq[] = '{2280, 0, 1000, 2000, 3000, 4413, 2413, 4413, 2413, 4413, 2413, 4545};
        int n0;
        do_reset(0);
        low_phase(3, 1);
        n0 = n_valid;
        rise(1);
        foreach (hi_seq[i]) step(hi_seq[i]);
        foreach (lo_seq[i]) step(lo_seq[i]);
        n_vec++; if (n_valid !== n0) begin n_err++; $display("FAIL hyst_spurious: got %0d strobes expected 0", n_valid - n0); end
        step(TH_HI);
        n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL hyst_valid: got %b expected 1", last_valid); end
        n_vec++; if (bus.cycles_high !== CW'(11)) begin n_err++; $display("FAIL hyst_hi: got %0d expected 11", bus.cycles_high); end
        n_vec++; if (bus.cycles_low !== CW'(12)) begin n_err++; $display("FAIL hyst_lo: got %0d expected 12", bus.cycles_low); end
        n_vec++; if (bus.period !== PW'(23)) begin n_err++; $display("FAIL hyst_period: got %0d expected 23", bus.period); end
    endtask

    task automatic test_high_at_reset();
        int n0;
        do_reset(V5);
        high_tail(37, 1);
        low_phase(50, 1);
        n0 = n_valid;
        rise(1);
        n_vec++; if (n_valid !== n0) begin n_err++; $display("FAIL hreset_partial: got %0d strobes expected 0", n_valid - n0); end
        high_tail(99, 1);
        low_phase(50, 1);
        rise(1);
        n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL hreset_valid: got %b expected 1", last_valid); end
        n_vec++; if (bus.cycles_high !== CW'(100)) begin n_err++; $display("FAIL hreset_hi: got %0d expected 100", bus.cycles_high); end
        n_vec++; if (bus.cycles_low !== CW'(50)) begin n_err++; $display("FAIL hreset_lo: got %0d expected 50", bus.cycles_low); end
        n_vec++; if (n_valid !== n0 + 1) begin n_err++; $display("FAIL hreset_count: got %0d expected 1", n_valid - n0); end
    endtask

    task automatic test_timeout_boundary();
        do_reset(0);
        low_phase(3, 0);
        rise(0);
        high_tail(TO - 1, 0);
        low_phase(TO, 0);
        rise(0);
        n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL tb_valid: got %b expected 1", last_valid); end
        n_vec++; if (bus.cycles_high !== CW'(TO)) begin n_err++; $display("FAIL tb_hi: got %0d expected %0d", bus.cycles_high, TO); end
        n_vec++; if (bus.cycles_low !== CW'(TO)) begin n_err++; $display("FAIL tb_lo: got %0d expected %0d", bus.cycles_low, TO); end
        n_vec++; if (bus.period !== PW'(2 * TO)) begin n_err++; $display("FAIL tb_period: got %0d expected %0d", bus.period, 2 * TO); end
        n_vec++; if (bus.stalled !== 1'b0) begin n_err++; $display("FAIL tb_stalled: got %b expected 0", bus.stalled); end
    endtask

    task automatic test_stall();
        int n0;
        do_reset(0);
        low_phase(3, 1);
        rise(1);
        high_tail(19, 1);
        low_phase(30, 1);
        rise(1);
        n_vec++; if (bus.period !== PW'(50)) begin n_err++; $display("FAIL stall_pre_period: got %0d expected 50", bus.period); end
        high_tail(TO - 1, 1);
        n_vec++; if (bus.stalled !== 1'b0) begin n_err++; $display("FAIL stall_early: got %b expected 0", bus.stalled); end
        step(V5);
        n_vec++; if (bus.stalled !== 1'b1) begin n_err++; $display("FAIL stall_set: got %b expected 1", bus.stalled); end
        n_vec++; if (bus.cycles_high !== CW'(20)) begin n_err++; $display("FAIL stall_hold_hi: got %0d expected 20", bus.cycles_high); end
        n_vec++; if (bus.cycles_low !== CW'(30)) begin n_err++; $display("FAIL stall_hold_lo: got %0d expected 30", bus.cycles_low); end
        n_vec++; if (bus.period !== PW'(50)) begin n_err++; $display("FAIL stall_hold_period: got %0d expected 50", bus.period); end
        blk_q.delete();
        high_tail(5, 1);
        low_phase(50, 1);
        n0 = n_valid;
        rise(1);
        n_vec++; if (n_valid !== n0) begin n_err++; $display("FAIL stall_resync: got %0d strobes expected 0", n_valid - n0); end
        n_vec++; if (bus.stalled !== 1'b1) begin n_err++; $display("FAIL stall_level: got %b expected 1", bus.stalled); end
        high_tail(99, 1);
        low_phase(50, 1);
        rise(1);
        n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume_valid: got %b expected 1", last_valid); end
        n_vec++; if (bus.period !== PW'(150)) begin n_err++; $display("FAIL stall_resume_period: got %0d expected 150", bus.period); end
        n_vec++; if (bus.stalled !== 1'b0) begin n_err++; $display("FAIL stall_clear: got %b expected 0", bus.stalled); end
    endtask

    task automatic test_mid_reset();
        int n0;
        do_reset(0);
        low_phase(3, 1);
        rise(1);
        for (int k = 0; k < 4; k++) begin
            high_tail(4, 1);
            low_phase(5 + k, 1);
            rise(1);
        end
        // periods 10, 11, 12, 13 -> block average floor(46 / 4)
        n_vec++; if (bus.avg_period !== PW'(11)) begin n_err++; $display("FAIL mid_pre_avg: got %0d expected 11", bus.avg_period); end
        high_tail(10, 1);
        @(negedge clk);
        I_RST  = 1'b1;
        bus.in = 16'(V5);
        @(posedge clk);
        #1;
        n_vec++; if (bus.cycles_high !== '0) begin n_err++; $display("FAIL mid_hi: got %0d expected 0", bus.cycles_high); end
        n_vec++; if (bus.cycles_low !== '0) begin n_err++; $display("FAIL mid_lo: got %0d expected 0", bus.cycles_low); end
        n_vec++; if (bus.period !== '0) begin n_err++; $display("FAIL mid_period: got %0d expected 0", bus.period); end
        n_vec++; if (bus.avg_period !== '0) begin n_err++; $display("FAIL mid_avg: got %0d expected 0", bus.avg_period); end
        @(negedge clk);
        I_RST = 1'b0;
        blk_q.delete();
        high_tail(20, 1);
        low_phase(50, 1);
        n0 = n_valid;
        rise(1);
        high_tail(99, 1);
        low_phase(50, 1);
        n_vec++; if (n_valid !== n0) begin n_err++; $display("FAIL mid_early: got %0d strobes expected 0", n_valid - n0); end
        rise(1);
        n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid: got %b expected 1", last_valid); end
        n_vec++; if (bus.cycles_high !== CW'(100)) begin n_err++; $display("FAIL mid_new_hi: got %0d expected 100", bus.cycles_high); end
    endtask

    task automatic test_back_to_back_random();
        int h, l, p, n0, sum;
        do_reset(0);
        low_phase(3, 0);
        rise(0);
        n0 = n_valid;
        for (int k = 0; k < 40; k++) begin
            h = (k < 2) ? 1 : int'($urandom_range(60, 1));
            l = (k < 2) ? 1 : int'($urandom_range(60, 1));
            high_tail(h - 1, 0);
            low_phase(l, 0);
            rise(0);
            p = h + l;
            blk_q.push_back(p);
            n_vec++; if (last_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected 1", k, last_valid); end
            n_vec++; if (bus.cycles_high !== CW'(h)) begin n_err++; $display("FAIL rnd_hi[%0d]: got %0d expected %0d", k, bus.cycles_high, h); end
            n_vec++; if (bus.cycles_low !== CW'(l)) begin n_err++; $display("FAIL rnd_lo[%0d]: got %0d expected %0d", k, bus.cycles_low, l); end
            n_vec++; if (bus.period !== PW'(p)) begin n_err++; $display("FAIL rnd_period[%0d]: got %0d expected %0d", k, bus.period, p); end
            n_vec++; if (n_valid !== n0 + k + 1) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, n_valid - n0, k + 1); end
            if (blk_q.size() == (1 << AL)) begin
                sum = 0;
                foreach (blk_q[i]) sum += blk_q[i];
                n_vec++; if (last_avg !== 1'b1) begin n_err++; $display("FAIL rnd_avg_valid[%0d]: got %b expected 1", k, last_avg); end
                n_vec++; if (bus.avg_period !== PW'(sum / (1 << AL))) begin n_err++; $display("FAIL rnd_avg[%0d]: got %0d expected %0d", k, bus.avg_period, sum / (1 << AL)); end
                blk_q.delete();
            end else begin
                n_vec++; if (last_avg !== 1'b0) begin n_err++; $display("FAIL rnd_avg_valid[%0d]: got %b expected 0", k, last_avg); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_averaging();
        test_hysteresis();
        test_high_at_reset();
        test_timeout_boundary();
        test_stall();
        test_mid_reset();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
